// File: rtl/pc_fetch_unit.sv
// PC register and instruction fetch: holds the current PC, fetches it over a req/ready handshake
// and presents the word to decode. Optional `PC_MISALIGN_TRAP_EN traps on misaligned next_pc.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_WAIT  = 15,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc_i,
  input  logic        stall_i,
  input  logic        retire_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        fetch_err_o,
  output logic        misalign_trap_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_HOLD  = 3'd2,
    S_ERR   = 3'd3,
    S_TRAP  = 3'd4
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;
  logic            req_q;
  logic            err_q;
  logic [CW-1:0]   wait_q;
  logic            xfer_s;
  logic            advance_s;
  logic [31:0]     aligned_pc_s;
`ifdef PC_MISALIGN_TRAP_EN
  logic            trap_q;
`endif

  assign xfer_s       = req_q & imem_ready_i;
  assign advance_s    = retire_i & ~stall_i;
  assign aligned_pc_s = next_pc_i & 32'hFFFF_FFFC;

  // Fetch FSM: state, PC, instruction latch and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          wait_q  <= '0;
        end
        S_FETCH: begin
          if (xfer_s) begin
            instr_q <= imem_rdata_i;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            wait_q  <= '0;
            state_q <= S_HOLD;
          end else if (wait_q == WAIT_LAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wait_q  <= wait_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_HOLD: begin
          if (advance_s) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            wait_q  <= '0;
`ifdef PC_MISALIGN_TRAP_EN
            pc_q <= next_pc_i;
            if (next_pc_i[1:0] != 2'b00) begin
              trap_q  <= 1'b1;
              req_q   <= 1'b0;
              state_q <= S_TRAP;
            end else begin
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
`else
            pc_q    <= aligned_pc_s;
            req_q   <= 1'b1;
            state_q <= S_FETCH;
`endif
          end else begin
            req_q <= 1'b0;
          end
        end
        S_ERR, S_TRAP: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park safely with no request outstanding
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
          state_q <= S_ERR;
        end
      endcase
    end
  end

  assign imem_req_o    = req_q;
  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign pc_plus_4_o   = pc_q + 32'd4;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign fetch_err_o   = err_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap_o = trap_q;
`else
  assign misalign_trap_o = 1'b0;
`endif

endmodule
